dmem_arbiter: RTL and testbench

- Shares the single-port data memory (DMEM) between two requesters.
  - Port 0: CPU core load/store.
  - Port 1: debug/loader master, which fills or inspects DMEM over a serial link.
- Round-robin arbitration, a burst lock for port 1, and a starvation guard for the core.
- Sits between CPU_Core's DMEM signals and the DMEM macro. Drives a core stall so the PC holds while the core is denied.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 84 ++++++++
 tb/tb_dmem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle joining the core port, the loader port and the DMEM macro.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // port 0: core load/store
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;
    logic              stall_core;
    // port 1: debug/loader master
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              lock1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;
    // DMEM macro side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1, lock1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0, stall_core,
        output gnt1, rvalid1, rdata1,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1, lock1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0, stall_core,
        input  gnt1, rvalid1, rdata1,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port DMEM: round-robin, loader burst lock,
// and a starvation guard that forces a core grant after MAX_WAIT denials.
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic           CLK,
    input  logic           RSTn,
    dmem_arbiter_if.slave  bus
);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic              last_gnt_q, last_gnt_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // Grants are gated by RSTn directly so nothing reaches DMEM while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RSTn) begin
            if (bus.req0 && bus.req1) begin
                if (last_gnt_q && bus.lock1 && (wait_cnt_q < MAX_W))
                    gnt1 = 1'b1;
                else if (last_gnt_q)
                    gnt0 = 1'b1;
                else
                    gnt1 = 1'b1;
            end else begin
                gnt0 = bus.req0;
                gnt1 = bus.req1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0)
            last_gnt_d = 1'b0;
        else if (gnt1)
            last_gnt_d = 1'b1;

        // Counts consecutive core denials; any core grant or idle core clears it.
        wait_cnt_d = '0;
        if (bus.req0 && !gnt0)
            wait_cnt_d = (wait_cnt_q < MAX_W) ? wait_cnt_q + 8'd1 : wait_cnt_q;

        rvalid0_d = gnt0 & ~bus.we0;
        rvalid1_d = gnt1 & ~bus.we1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            last_gnt_q <= 1'b1;
            wait_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign addr_mux  = gnt1 ? bus.addr1  : bus.addr0;
    assign wdata_mux = gnt1 ? bus.wdata1 : bus.wdata0;

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.stall_core = bus.req0 & ~gnt0;
    assign bus.mem_addr   = addr_mux;
    assign bus.mem_wdata  = wdata_mux;
    assign bus.mem_we     = (gnt0 & bus.we0) | (gnt1 & bus.we1);
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.rdata0     = bus.mem_rdata;
    assign bus.rdata1     = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table with hand-derived grants, a read
// scoreboard against a reference memory, plus burst and reset sequences.
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 8;

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;
    always #5 CLK = ~CLK;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // DMEM macro model: synchronous read, data valid the cycle after the address.
    logic [DW-1:0] mem [1024];
    bit            mem_wr [1024];
    always @(posedge CLK) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr]    <= bus.mem_wdata;
            mem_wr[bus.mem_addr] <= 1'b1;
        end
        bus.mem_rdata <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : init_pat(bus.mem_addr);
    end

    // Reference memory kept from the expected transfers only.
    logic [DW-1:0] ref_mem [1024];
    bit            ref_wr [1024];
    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_pat(a);
    endfunction

    typedef struct {
        logic          req0, we0;
        logic [AW-1:0] addr0;
        logic [DW-1:0] wdata0;
        logic          req1, we1, lock1;
        logic [AW-1:0] addr1;
        logic [DW-1:0] wdata1;
        logic          g0, g1;
    } vec_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    rd_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic r1, input logic w1,
                                input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic g0, input logic g1);
        vec_t v;
        v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = r1; v.we1 = w1; v.lock1 = l1; v.addr1 = a1; v.wdata1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks it at the falling edge.
    task automatic step(input vec_t v);
        logic          er0, er1;
        logic [DW-1:0] ed;
        bus.req0 = v.req0; bus.we0 = v.we0; bus.addr0 = v.addr0; bus.wdata0 = v.wdata0;
        bus.req1 = v.req1; bus.we1 = v.we1; bus.addr1 = v.addr1; bus.wdata1 = v.wdata1;
        bus.lock1 = v.lock1;
        @(negedge CLK);
        er0 = 1'b0; er1 = 1'b0; ed = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (sb[0].port) er1 = 1'b1; else er0 = 1'b1;
            ed = sb[0].data;
            void'(sb.pop_front());
        end
        chk("rvalid0", 32'(bus.rvalid0), 32'(er0));
        chk("rvalid1", 32'(bus.rvalid1), 32'(er1));
        if (er0) chk("rdata0", bus.rdata0, ed);
        if (er1) chk("rdata1", bus.rdata1, ed);
        chk("gnt0", 32'(bus.gnt0), 32'(v.g0));
        chk("gnt1", 32'(bus.gnt1), 32'(v.g1));
        chk("stall_core", 32'(bus.stall_core), 32'(v.req0 & ~v.g0));
        chk("mem_we", 32'(bus.mem_we), 32'((v.g0 & v.we0) | (v.g1 & v.we1)));
        if (v.g0 | v.g1) chk("mem_addr", 32'(bus.mem_addr), 32'(v.g1 ? v.addr1 : v.addr0));
        if ((v.g0 & v.we0) | (v.g1 & v.we1))
            chk("mem_wdata", bus.mem_wdata, v.g1 ? v.wdata1 : v.wdata0);
        chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
        chk("we_no_gnt", 32'(bus.mem_we & ~(bus.gnt0 | bus.gnt1)), 32'd0);
        if (v.g0 && !v.we0) sb.push_back('{port: 1'b0, data: ref_read(v.addr0), due: cyc + 1});
        if (v.g1 && !v.we1) sb.push_back('{port: 1'b1, data: ref_read(v.addr1), due: cyc + 1});
        if (v.g0 && v.we0) begin ref_mem[v.addr0] = v.wdata0; ref_wr[v.addr0] = 1'b1; end
        if (v.g1 && v.we1) begin ref_mem[v.addr1] = v.wdata1; ref_wr[v.addr1] = 1'b1; end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Short asynchronous reset pulse between edges; in-flight reads are discarded.
    task automatic pulse_reset(input logic r0, input logic r1);
        bus.req0 = r0; bus.we0 = 1'b0; bus.req1 = r1; bus.we1 = 1'b0; bus.lock1 = 1'b0;
        #1 RSTn = 1'b0;
        #1;
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
        sb.delete();
        #1 RSTn = 1'b1;
    endtask

    vec_t tbl [15];
    vec_t idle;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle = mk(0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 0);
        //              r0 w0 addr0    wdata0        r1 w1 l1 addr1    wdata1        g0 g1
        tbl[0]  = mk(1, 0, 10'h004, 0,            1, 0, 0, 10'h008, 0,            1, 0);
        tbl[1]  = mk(1, 0, 10'h004, 0,            1, 0, 0, 10'h008, 0,            0, 1);
        tbl[2]  = mk(1, 0, 10'h004, 0,            1, 0, 0, 10'h008, 0,            1, 0);
        tbl[3]  = mk(1, 0, 10'h004, 0,            1, 0, 0, 10'h008, 0,            0, 1);
        tbl[4]  = mk(1, 0, 10'h004, 0,            0, 0, 0, 10'h008, 0,            1, 0);
        tbl[5]  = idle;
        tbl[6]  = mk(1, 0, 10'h005, 0,            0, 0, 1, 10'h008, 0,            1, 0);
        tbl[7]  = mk(0, 0, 10'h000, 0,            1, 1, 0, 10'h020, 32'hDEADBEEF, 0, 1);
        tbl[8]  = mk(1, 0, 10'h020, 0,            0, 0, 0, 10'h000, 0,            1, 0);
        tbl[9]  = mk(1, 1, 10'h030, 32'h12345678, 1, 0, 1, 10'h020, 0,            0, 1);
        tbl[10] = mk(1, 1, 10'h030, 32'h12345678, 1, 0, 1, 10'h020, 0,            0, 1);
        tbl[11] = mk(1, 1, 10'h030, 32'h12345678, 0, 0, 0, 10'h000, 0,            1, 0);
        tbl[12] = mk(0, 0, 10'h000, 0,            1, 0, 0, 10'h030, 0,            0, 1);
        tbl[13] = idle;
        tbl[14] = idle;

        // Power-on reset with both ports requesting writes.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 1'b0;
        #1 RSTn = 1'b0;
        @(negedge CLK);
        chk("por_gnt0", 32'(bus.gnt0), 32'd0);
        chk("por_gnt1", 32'(bus.gnt1), 32'd0);
        chk("por_mem_we", 32'(bus.mem_we), 32'd0);
        chk("por_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        #2 RSTn = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 15; i++) step(tbl[i]);

        // Locked loader burst against a continuously requesting core.
        pulse_reset(1'b0, 1'b0);
        begin
            logic [AW-1:0] a1;
            logic          g0;
            a1 = 10'h010;
            for (int k = 0; k < 19; k++) begin
                g0 = (k == 1 + MW) || (k == 2 + 2 * MW);
                step(mk(k >= 1, 0, 10'h040, 0, 1, 1, 1, a1, 32'(a1), g0, !g0));
                if (!g0) a1 = a1 + 10'd1;
            end
        end
        step(idle);
        step(mk(1, 0, 10'h015, 0, 0, 0, 0, 10'h000, 0, 1, 0));
        step(idle);

        // Reset landing while a core read is in flight and both ports request.
        step(mk(1, 0, 10'h020, 0, 0, 0, 0, 10'h004, 0, 1, 0));
        pulse_reset(1'b1, 1'b1);
        step(mk(1, 0, 10'h020, 0, 1, 0, 0, 10'h004, 0, 1, 0));
        step(mk(1, 0, 10'h020, 0, 1, 0, 0, 10'h004, 0, 0, 1));
        step(idle);
        step(idle);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
